// File: rtl/orv64_fetch_ctrl_if.sv
// Fetch-control bundle: instruction-buffer request/response, flush/idle,
// redirect and FENCE.I controls, and the decode-side dequeue port.
interface orv64_fetch_ctrl_if #(
    parameter int VADDR_WIDTH = 39
);
    logic                   if2ib_en;
    logic [VADDR_WIDTH-1:0] if2ib_pc;
    logic                   ib2if_valid;
    logic [31:0]            ib2if_inst;
    logic                   ib2if_is_rvc;
    logic                   ib2if_excp_valid;
    logic                   ib2if_is_half1_excp;
    logic [3:0]             ib2if_excp_cause;
    logic                   ib_flush;
    logic                   ib_idle;
    logic                   redirect_valid;
    logic [VADDR_WIDTH-1:0] redirect_pc;
    logic                   fence_i_valid;
    logic [VADDR_WIDTH-1:0] fence_i_pc;
    logic                   deq_valid;
    logic                   deq_ready;
    logic [VADDR_WIDTH-1:0] deq_pc;
    logic [31:0]            deq_inst;
    logic                   deq_is_rvc;
    logic                   deq_excp_valid;
    logic [3:0]             deq_excp_cause;
    logic                   deq_is_half1_excp;

    // Fetch-control side
    modport master (
        output if2ib_en, if2ib_pc, ib_flush,
        output deq_valid, deq_pc, deq_inst, deq_is_rvc,
        output deq_excp_valid, deq_excp_cause, deq_is_half1_excp,
        input  ib2if_valid, ib2if_inst, ib2if_is_rvc,
        input  ib2if_excp_valid, ib2if_is_half1_excp, ib2if_excp_cause,
        input  ib_idle, redirect_valid, redirect_pc,
        input  fence_i_valid, fence_i_pc, deq_ready
    );

    // Instruction buffer / pipeline side
    modport slave (
        input  if2ib_en, if2ib_pc, ib_flush,
        input  deq_valid, deq_pc, deq_inst, deq_is_rvc,
        input  deq_excp_valid, deq_excp_cause, deq_is_half1_excp,
        output ib2if_valid, ib2if_inst, ib2if_is_rvc,
        output ib2if_excp_valid, ib2if_is_half1_excp, ib2if_excp_cause,
        output ib_idle, redirect_valid, redirect_pc,
        output fence_i_valid, fence_i_pc, deq_ready
    );
endinterface

// File: rtl/orv64_fetch_ctrl.sv
// ORV64 fetch controller: issues PCs to the instruction buffer, queues
// returned instructions for decode, handles redirects, fetch exceptions
// and FENCE.I drain/resume.
module orv64_fetch_ctrl #(
    parameter int                     VADDR_WIDTH = 39,
    parameter int                     QDEPTH      = 4,
    parameter logic [VADDR_WIDTH-1:0] RESET_PC    = 'h8000_0000
) (
    input  logic               clk,
    input  logic               rst,
    orv64_fetch_ctrl_if.master bus
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CNT_FULL  = CW'(QDEPTH);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(QDEPTH - 2);

    localparam logic [1:0] ST_FETCH      = 2'd0;
    localparam logic [1:0] ST_EXCP_WAIT  = 2'd1;
    localparam logic [1:0] ST_FENCE_WAIT = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [VADDR_WIDTH-1:0] rff_pc_q, rff_pc_d;
    logic [VADDR_WIDTH-1:0] saved_pc_q, saved_pc_d;
    logic [CW-1:0]          count_q, count_d;
    logic [PW-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
    logic                   ib_flush_q, ib_flush_d;

    logic [VADDR_WIDTH-1:0] q_pc_q    [QDEPTH];
    logic [31:0]            q_inst_q  [QDEPTH];
    logic                   q_rvc_q   [QDEPTH];
    logic                   q_excp_q  [QDEPTH];
    logic [3:0]             q_cause_q [QDEPTH];
    logic                   q_half1_q [QDEPTH];

    logic [VADDR_WIDTH-1:0] step, pc_inc;
    logic                   in_fw, redir_go, flush, enq, deq, deq_valid_w, fw_exit;

    assign step     = bus.ib2if_is_rvc ? VADDR_WIDTH'(2) : VADDR_WIDTH'(4);
    assign pc_inc   = rff_pc_q + step;
    assign in_fw    = (state_q == ST_FENCE_WAIT);
    // In FENCE_WAIT a redirect only retargets the resume PC; the queue is already empty.
    assign redir_go = bus.redirect_valid & ~bus.fence_i_valid & ~in_fw;
    assign flush    = bus.fence_i_valid | redir_go;
    assign enq      = bus.ib2if_valid & ~bus.redirect_valid & ~bus.fence_i_valid & ~in_fw;
    assign deq_valid_w = ~rst & (count_q != '0);
    assign deq      = deq_valid_w & bus.deq_ready;
    // ib_flush_q is high exactly on the first FENCE_WAIT cycle, which also enforces the 2-cycle minimum.
    assign fw_exit  = in_fw & bus.ib_idle & ~ib_flush_q;

    // One slot is held back so a response to the last issued request always fits.
    assign bus.if2ib_en = ~rst & (state_q == ST_FETCH) & (count_q <= CNT_LIMIT)
                        & ~bus.redirect_valid & ~bus.fence_i_valid;
    assign bus.if2ib_pc = bus.redirect_valid ? bus.redirect_pc :
                          bus.ib2if_valid    ? pc_inc : rff_pc_q;
    assign bus.ib_flush = ~rst & ib_flush_q;

    assign bus.deq_valid         = deq_valid_w;
    assign bus.deq_pc            = q_pc_q[rptr_q];
    assign bus.deq_inst          = q_inst_q[rptr_q];
    assign bus.deq_is_rvc        = q_rvc_q[rptr_q];
    assign bus.deq_excp_valid    = q_excp_q[rptr_q];
    assign bus.deq_excp_cause    = q_cause_q[rptr_q];
    assign bus.deq_is_half1_excp = q_half1_q[rptr_q];

    // Next-state computation for FSM, PCs and queue bookkeeping
    always_comb begin
        state_d    = state_q;
        rff_pc_d   = rff_pc_q;
        saved_pc_d = saved_pc_q;
        ib_flush_d = bus.fence_i_valid;
        count_d    = count_q + CW'(enq) - CW'(deq);
        wptr_d     = wptr_q + PW'(enq);
        rptr_d     = rptr_q + PW'(deq);

        if (flush) begin
            count_d = '0;
            wptr_d  = '0;
            rptr_d  = '0;
        end

        if (bus.fence_i_valid) begin
            state_d    = ST_FENCE_WAIT;
            saved_pc_d = bus.fence_i_pc;
        end else if (redir_go) begin
            state_d  = ST_FETCH;
            rff_pc_d = bus.redirect_pc;
        end else if (in_fw) begin
            if (bus.redirect_valid) begin
                saved_pc_d = bus.redirect_pc;
            end
            if (fw_exit) begin
                state_d  = ST_FETCH;
                rff_pc_d = bus.redirect_valid ? bus.redirect_pc : saved_pc_q;
            end
        end else if (enq) begin
            rff_pc_d = pc_inc;
            if (state_q == ST_FETCH && bus.ib2if_excp_valid) begin
                state_d = ST_EXCP_WAIT;
            end
        end
    end

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            rff_pc_q   <= RESET_PC;
            saved_pc_q <= RESET_PC;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            ib_flush_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rff_pc_q   <= rff_pc_d;
            saved_pc_q <= saved_pc_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            ib_flush_q <= ib_flush_d;
        end
    end

    // Queue storage written at the tail on enqueue; contents are don't-care when empty
    always_ff @(posedge clk) begin
        if (enq) begin
            q_pc_q[wptr_q]    <= rff_pc_q;
            q_inst_q[wptr_q]  <= bus.ib2if_inst;
            q_rvc_q[wptr_q]   <= bus.ib2if_is_rvc;
            q_excp_q[wptr_q]  <= bus.ib2if_excp_valid;
            q_cause_q[wptr_q] <= bus.ib2if_excp_cause;
            q_half1_q[wptr_q] <= bus.ib2if_is_half1_excp;
        end
    end

    // Request throttling must make enqueue into a full queue unreachable
    always_ff @(posedge clk) begin
        assert (rst || !(enq && count_q == CNT_FULL));
    end
endmodule

// File: tb/tb_orv64_fetch_ctrl.sv
// Directed bench for orv64_fetch_ctrl.
module tb_orv64_fetch_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   passes;

    orv64_fetch_ctrl_if #(.VADDR_WIDTH(39)) bus ();

    orv64_fetch_ctrl #(
        .VADDR_WIDTH(39),
        .QDEPTH     (4),
        .RESET_PC   (39'h8000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.ib2if_valid         = 1'b0;
        bus.ib2if_inst          = 32'h0;
        bus.ib2if_is_rvc        = 1'b0;
        bus.ib2if_excp_valid    = 1'b0;
        bus.ib2if_is_half1_excp = 1'b0;
        bus.ib2if_excp_cause    = 4'h0;
        bus.redirect_valid      = 1'b0;
        bus.redirect_pc         = '0;
        bus.fence_i_valid       = 1'b0;
        bus.fence_i_pc          = '0;
    endtask

    task automatic resp(input logic rvc, input logic [31:0] inst);
        bus.ib2if_valid  = 1'b1;
        bus.ib2if_is_rvc = rvc;
        bus.ib2if_inst   = inst;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst = 1'b1;
        quiet();
        bus.ib_idle   = 1'b1;
        bus.deq_ready = 1'b0;
        tick();
        tick();
        #1;
        chk("rst_en", 64'(bus.if2ib_en), 64'(0));
        chk("rst_flush", 64'(bus.ib_flush), 64'(0));
        chk("rst_deq_valid", 64'(bus.deq_valid), 64'(0));

        // first cycle out of reset
        rst = 1'b0;
        #1;
        chk("post_rst_en", 64'(bus.if2ib_en), 64'(1));
        chk("post_rst_pc", 64'(bus.if2ib_pc), 64'h8000_0000);

        // RVC, 32-bit, RVC responses with decode always ready
        bus.deq_ready = 1'b1;
        tick(); resp(1'b1, 32'h0000_0001); #1;
        chk("r1_pc", 64'(bus.if2ib_pc), 64'h8000_0002);
        chk("r1_deq_valid", 64'(bus.deq_valid), 64'(0));
        tick(); resp(1'b0, 32'h0000_0013); #1;
        chk("r2_pc", 64'(bus.if2ib_pc), 64'h8000_0006);
        chk("r2_deq_pc", 64'(bus.deq_pc), 64'h8000_0000);
        chk("r2_deq_rvc", 64'(bus.deq_is_rvc), 64'(1));
        tick(); resp(1'b1, 32'h0000_4501); #1;
        chk("r3_pc", 64'(bus.if2ib_pc), 64'h8000_0008);
        chk("r3_deq_pc", 64'(bus.deq_pc), 64'h8000_0002);
        chk("r3_deq_inst", 64'(bus.deq_inst), 64'h13);
        tick(); quiet(); #1;
        chk("r4_deq_pc", 64'(bus.deq_pc), 64'h8000_0006);
        chk("r4_deq_inst", 64'(bus.deq_inst), 64'h4501);
        chk("r4_pc", 64'(bus.if2ib_pc), 64'h8000_0008);
        tick(); #1;
        chk("r5_empty", 64'(bus.deq_valid), 64'(0));

        // back-pressure: request enable drops at three entries, fourth still lands
        bus.deq_ready = 1'b0;
        resp(1'b0, 32'h0000_0013); #1;
        chk("bp0_en", 64'(bus.if2ib_en), 64'(1));
        tick(); #1;
        chk("bp1_en", 64'(bus.if2ib_en), 64'(1));
        tick(); #1;
        chk("bp2_en", 64'(bus.if2ib_en), 64'(1));
        tick(); #1;
        chk("bp3_en", 64'(bus.if2ib_en), 64'(0));
        tick(); quiet(); #1;
        chk("bp4_en", 64'(bus.if2ib_en), 64'(0));
        bus.deq_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_drain_valid", 64'(bus.deq_valid), 64'(1));
            chk("bp_drain_pc", 64'(bus.deq_pc), 64'h8000_0008 + 64'(4 * i));
            tick();
        end
        #1;
        chk("bp_drained", 64'(bus.deq_valid), 64'(0));
        chk("bp_next_pc", 64'(bus.if2ib_pc), 64'h8000_0018);

        // redirect with two queued entries and a concurrent response
        bus.deq_ready = 1'b0;
        resp(1'b0, 32'h0000_0013);
        tick();
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 39'h1000;
        #1;
        chk("rd_pc_same_cycle", 64'(bus.if2ib_pc), 64'h1000);
        chk("rd_queued", 64'(bus.deq_valid), 64'(1));
        tick(); quiet(); #1;
        chk("rd_flushed", 64'(bus.deq_valid), 64'(0));
        chk("rd_en", 64'(bus.if2ib_en), 64'(1));
        chk("rd_pc", 64'(bus.if2ib_pc), 64'h1000);

        // fetch exception: entry carries cause, requests stop until redirect
        bus.deq_ready = 1'b1;
        resp(1'b0, 32'h0);
        bus.ib2if_excp_valid    = 1'b1;
        bus.ib2if_excp_cause    = 4'h1;
        bus.ib2if_is_half1_excp = 1'b1;
        tick(); quiet(); #1;
        chk("ex_deq_valid", 64'(bus.deq_valid), 64'(1));
        chk("ex_deq_pc", 64'(bus.deq_pc), 64'h1000);
        chk("ex_deq_excp", 64'(bus.deq_excp_valid), 64'(1));
        chk("ex_deq_cause", 64'(bus.deq_excp_cause), 64'h1);
        chk("ex_deq_half1", 64'(bus.deq_is_half1_excp), 64'(1));
        chk("ex_en0", 64'(bus.if2ib_en), 64'(0));
        tick(); #1;
        chk("ex_en1", 64'(bus.if2ib_en), 64'(0));
        chk("ex_empty", 64'(bus.deq_valid), 64'(0));
        tick(); #1;
        chk("ex_en2", 64'(bus.if2ib_en), 64'(0));
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 39'h3000;
        tick(); quiet(); #1;
        chk("ex_rd_en", 64'(bus.if2ib_en), 64'(1));
        chk("ex_rd_pc", 64'(bus.if2ib_pc), 64'h3000);

        // FENCE.I with the buffer busy for several cycles
        bus.ib_idle       = 1'b0;
        bus.fence_i_valid = 1'b1;
        bus.fence_i_pc    = 39'h2000;
        #1;
        chk("fi_en_req", 64'(bus.if2ib_en), 64'(0));
        chk("fi_no_flush_yet", 64'(bus.ib_flush), 64'(0));
        tick(); quiet(); #1;
        chk("fi_flush_pulse", 64'(bus.ib_flush), 64'(1));
        chk("fi_en_w0", 64'(bus.if2ib_en), 64'(0));
        tick(); resp(1'b0, 32'h13); #1;
        chk("fi_flush_one", 64'(bus.ib_flush), 64'(0));
        tick(); quiet();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("fi_wait_en", 64'(bus.if2ib_en), 64'(0));
            chk("fi_wait_flush", 64'(bus.ib_flush), 64'(0));
            chk("fi_drop", 64'(bus.deq_valid), 64'(0));
            tick();
        end
        bus.ib_idle = 1'b1;
        #1;
        chk("fi_idle_en", 64'(bus.if2ib_en), 64'(0));
        tick(); #1;
        chk("fi_resume_en", 64'(bus.if2ib_en), 64'(1));
        chk("fi_resume_pc", 64'(bus.if2ib_pc), 64'h2000);

        // FENCE.I and redirect together: fence wins
        bus.fence_i_valid  = 1'b1;
        bus.fence_i_pc     = 39'h4000;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 39'h5000;
        tick(); quiet(); #1;
        chk("fr_flush", 64'(bus.ib_flush), 64'(1));
        chk("fr_en0", 64'(bus.if2ib_en), 64'(0));
        tick(); #1;
        chk("fr_en1", 64'(bus.if2ib_en), 64'(0));
        tick(); #1;
        chk("fr_resume_en", 64'(bus.if2ib_en), 64'(1));
        chk("fr_resume_pc", 64'(bus.if2ib_pc), 64'h4000);

        // redirect during FENCE_WAIT replaces the resume PC
        bus.ib_idle       = 1'b0;
        bus.fence_i_valid = 1'b1;
        bus.fence_i_pc    = 39'h7000;
        tick(); quiet();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 39'h6000;
        #1;
        chk("fw_rd_en", 64'(bus.if2ib_en), 64'(0));
        tick(); quiet();
        bus.ib_idle = 1'b1;
        #1;
        chk("fw_rd_wait", 64'(bus.if2ib_en), 64'(0));
        tick(); #1;
        chk("fw_rd_resume_en", 64'(bus.if2ib_en), 64'(1));
        chk("fw_rd_resume_pc", 64'(bus.if2ib_pc), 64'h6000);

        // reset in the middle of operation discards queued entries
        bus.deq_ready = 1'b0;
        resp(1'b0, 32'h13);
        tick();
        tick(); quiet();
        rst = 1'b1;
        #1;
        chk("mr_en", 64'(bus.if2ib_en), 64'(0));
        chk("mr_deq_valid", 64'(bus.deq_valid), 64'(0));
        tick();
        rst = 1'b0;
        #1;
        chk("mr_after_deq", 64'(bus.deq_valid), 64'(0));
        chk("mr_after_en", 64'(bus.if2ib_en), 64'(1));
        chk("mr_after_pc", 64'(bus.if2ib_pc), 64'h8000_0000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
